// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state type
// and the small access-legality / byte-lane helpers used by the datapath.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WB,
        S_DONE
    } lsu_state_t;

    // Stores only have signed-agnostic widths, so BU/HU codes are illegal there.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'd1:    return lo[0];
            2'd2:    return lo != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'd0:    return 4'b0001 << lo;
            2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data replication/strobes and
// load lane selection with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    assign st_wstrb = lane_strobe(st_funct3, st_lo);

    // Each byte lane carries the byte, the matching half-word byte, or the word byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign st_wdata[8*gi +: 8] =
                (st_funct3[1:0] == 2'd0) ? st_data[7:0] :
                (st_funct3[1:0] == 2'd1) ? st_data[8*(gi%2) +: 8] :
                                           st_data[8*gi +: 8];
        end
    endgenerate

    assign shifted = ld_rdata >> {ld_lo, 3'b000};

    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {24'd0, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: one memory access per issue over a req/ack
// bus, with registered bus outputs and a one-cycle register-file writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   base,
    input  logic [11:0]       offset,
    input  logic [XLEN-1:0]   store_data,
    input  logic [4:0]        dest,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [4:0]        rf_dest,
    output logic [XLEN-1:0]   rf_rd
);

    lsu_state_t        state_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              fault_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [XLEN-1:0]   mem_wdata_reg;
    logic [3:0]        mem_wstrb_reg;
    logic              rf_we_reg;
    logic [4:0]        rf_dest_reg;
    logic [XLEN-1:0]   rf_rd_reg;
    logic              is_store_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        addr_lo_reg;

    logic [XLEN-1:0]   addr_next;
    logic              reject_next;
    logic [XLEN-1:0]   st_wdata;
    logic [3:0]        st_wstrb;
    logic [XLEN-1:0]   ld_data;

    assign addr_next   = base + {{(XLEN-12){offset[11]}}, offset};
    assign reject_next = !f3_legal(is_store, funct3) || misaligned(funct3, addr_next[1:0]);

    // Store side works on the issuing operands; load side on the latched access.
    lsu_align u_align (
        .st_funct3 (funct3),
        .st_lo     (addr_next[1:0]),
        .st_data   (store_data),
        .st_wdata  (st_wdata),
        .st_wstrb  (st_wstrb),
        .ld_funct3 (funct3_reg),
        .ld_lo     (addr_lo_reg),
        .ld_rdata  (mem_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= 4'b0000;
            rf_we_reg     <= 1'b0;
            rf_dest_reg   <= 5'd0;
            rf_rd_reg     <= '0;
            is_store_reg  <= 1'b0;
            funct3_reg    <= 3'd0;
            addr_lo_reg   <= 2'd0;
        end else begin
            done_reg  <= 1'b0;
            fault_reg <= 1'b0;
            rf_we_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy_reg     <= 1'b1;
                        is_store_reg <= is_store;
                        funct3_reg   <= funct3;
                        addr_lo_reg  <= addr_next[1:0];
                        rf_dest_reg  <= dest;
                        if (reject_next) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                            fault_reg <= 1'b1;
                        end else begin
                            state_reg     <= S_REQ;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= is_store;
                            mem_addr_reg  <= addr_next[ADDR_W-1:0];
                            mem_wdata_reg <= st_wdata;
                            mem_wstrb_reg <= is_store ? st_wstrb : 4'b0000;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        done_reg    <= 1'b1;
                        if (is_store_reg) begin
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_WB;
                            rf_rd_reg <= ld_data;
                            // x0 is hardwired zero: complete the load but never write it.
                            rf_we_reg <= (rf_dest_reg != 5'd0);
                        end
                    end
                end
                S_WB, S_DONE: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign fault     = fault_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign rf_we     = rf_we_reg;
    assign rf_dest   = rf_dest_reg;
    assign rf_rd     = rf_rd_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a transaction-level timeline model
// sets per-cycle expectations, and one negedge process compares them.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [11:0] offset;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        busy, done, fault, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_rd;

    int n_tests = 0;
    int n_fail  = 0;

    // expectations for the current cycle
    logic        chk_en = 1'b0;
    logic        e_busy, e_req, e_we, e_done, e_fault, e_rf_we;
    logic [31:0] e_addr, e_wdata, e_rd;
    logic [3:0]  e_wstrb;
    logic [4:0]  e_dest;

    // observation counters and captures
    int          cnt_req = 0, cnt_rfwe = 0, cnt_done = 0, cnt_fault = 0;
    logic [31:0] cap_addr, cap_wdata, cap_rd;
    logic [3:0]  cap_wstrb;
    logic        cap_we;
    logic [4:0]  cap_dest;

    load_store_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .base       (base),
        .offset     (offset),
        .store_data (store_data),
        .dest       (dest),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_dest    (rf_dest),
        .rf_rd      (rf_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic m_legal(input logic st, input logic [2:0] f3);
        if (st) return f3 < 3'd3;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        sz = 1 << (f3 % 4);
        return (f3 % 4 < 3) && ((a % sz) != 0);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0) return (d % 256) * 32'h0101_0101;
        if (f3 == 3'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd0) return 4'(1 << (a % 4));
        if (f3 == 3'd1) return ((a % 4) == 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'd4: v = v % 256;
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'd5: v = v % 65536;
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic set_idle();
        e_busy = 0; e_req = 0; e_we = 0; e_done = 0; e_fault = 0; e_rf_we = 0;
        e_addr = 0; e_wdata = 0; e_wstrb = 0; e_dest = 0; e_rd = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (mem_req) cnt_req <= cnt_req + 1;
        if (rf_we)   cnt_rfwe <= cnt_rfwe + 1;
        if (done)    cnt_done <= cnt_done + 1;
        if (done && fault) cnt_fault <= cnt_fault + 1;
        if (mem_req) begin
            cap_addr <= mem_addr; cap_we <= mem_we; cap_wdata <= mem_wdata; cap_wstrb <= mem_wstrb;
        end
        if (rf_we) begin
            cap_rd <= rf_rd; cap_dest <= rf_dest;
        end
        if (chk_en) begin
            chk("busy", busy, e_busy);
            chk("mem_req", mem_req, e_req);
            chk("done", done, e_done);
            chk("fault", fault, e_fault);
            chk("rf_we", rf_we, e_rf_we);
            if (e_req) begin
                chk("mem_we", mem_we, e_we);
                chk("mem_addr", mem_addr, e_addr);
                if (e_we) begin
                    chk("mem_wdata", mem_wdata, e_wdata);
                    chk("mem_wstrb", mem_wstrb, e_wstrb);
                end
            end
            if (e_rf_we) begin
                chk("rf_dest", rf_dest, e_dest);
                chk("rf_rd", rf_rd, e_rd);
            end
        end
    end

    // One whole transaction: start in the current cycle, ack after dly extra REQ cycles.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [11:0] off, input logic [31:0] sd, input logic [4:0] d,
                         input logic [31:0] rdata, input int dly, input logic extra);
        logic [31:0] a;
        logic        bad;
        a   = b + 32'($signed(off));
        bad = !m_legal(st, f3) || m_misaligned(f3, a);
        $display("[TB] op st=%0b f3=%0d addr=%h dest=%0d dly=%0d fault=%0b", st, f3, a, d, dly, bad);
        start = 1; is_store = st; funct3 = f3; base = b; offset = off;
        store_data = sd; dest = d;
        mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
        step();
        start = extra;
        if (extra) begin
            is_store = ~st; funct3 = 3'($urandom); base = $urandom; offset = 12'($urandom);
            store_data = $urandom; dest = 5'($urandom);
        end
        mem_ack = 0;
        if (bad) begin
            set_idle();
            e_busy = 1; e_done = 1; e_fault = 1;
            step();
            start = 0;
        end else begin
            for (int c = 1; c <= dly + 1; c++) begin
                set_idle();
                e_busy = 1; e_req = 1; e_we = st; e_addr = a;
                e_wdata = m_wdata(f3, sd); e_wstrb = m_wstrb(f3, a);
                mem_ack   = (c == dly + 1);
                mem_rdata = mem_ack ? rdata : $urandom;
                step();
                start = 0;
            end
            mem_ack = 0;
            set_idle();
            e_busy = 1; e_done = 1;
            e_rf_we = !st && (d != 5'd0);
            e_dest = d; e_rd = m_load(f3, a, rdata);
            step();
        end
        set_idle();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
            step();
        end
        mem_ack = 0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, w0, d0, f0;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] b;
        logic [11:0] off;

        rst_n = 0; start = 0; is_store = 0; funct3 = 0; base = 0; offset = 0;
        store_data = 0; dest = 0; mem_ack = 0; mem_rdata = 0;
        set_idle();
        step(); step();
        chk("rst_busy", busy, 0);   chk("rst_done", done, 0);   chk("rst_fault", fault, 0);
        chk("rst_req", mem_req, 0); chk("rst_we", mem_we, 0);   chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0); chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_rfwe", rf_we, 0);  chk("rst_dest", rf_dest, 0); chk("rst_rd", rf_rd, 0);
        rst_n = 1;
        step();
        chk_en = 1;

        // LW 0x100+4, ack two cycles after mem_req
        w0 = cnt_rfwe;
        do_op(0, 3'd2, 32'h100, 12'd4, 32'h0, 5'd5, 32'hDEADBEEF, 2, 0);
        chk("lw_addr", cap_addr, 32'h104);  chk("lw_we", cap_we, 0);
        chk("lw_rd", cap_rd, 32'hDEADBEEF); chk("lw_dest", cap_dest, 5);
        chk("lw_rfwe_cycles", cnt_rfwe - w0, 1);

        do_op(0, 3'd0, 32'h103, 12'd0, 32'h0, 5'd9, 32'h80123456, 0, 0);
        chk("lb_rd", cap_rd, 32'hFFFFFF80);
        do_op(0, 3'd4, 32'h103, 12'd0, 32'h0, 5'd9, 32'h80123456, 1, 0);
        chk("lbu_rd", cap_rd, 32'h00000080);

        w0 = cnt_rfwe; d0 = cnt_done;
        do_op(1, 3'd1, 32'h200, 12'hFFE, 32'h1234BEEF, 5'd3, 32'h0, 1, 0);
        chk("sh_addr", cap_addr, 32'h1FE);   chk("sh_wstrb", cap_wstrb, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'hBEEFBEEF);
        chk("sh_no_rfwe", cnt_rfwe - w0, 0); chk("sh_done", cnt_done - d0, 1);

        r0 = cnt_req; f0 = cnt_fault; w0 = cnt_rfwe;
        do_op(0, 3'd2, 32'h102, 12'd0, 32'h0, 5'd4, 32'h0, 0, 0);
        do_op(0, 3'd3, 32'h100, 12'd0, 32'h0, 5'd4, 32'h0, 0, 0);
        chk("fault_no_req", cnt_req - r0, 0); chk("fault_count", cnt_fault - f0, 2);
        chk("fault_no_rfwe", cnt_rfwe - w0, 0);

        r0 = cnt_req; d0 = cnt_done;
        do_op(0, 3'd2, 32'h300, 12'd8, 32'h0, 5'd6, 32'h11223344, 2, 1);
        chk("busy_req_cycles", cnt_req - r0, 3); chk("busy_one_done", cnt_done - d0, 1);

        w0 = cnt_rfwe; d0 = cnt_done;
        do_op(0, 3'd2, 32'h400, 12'd0, 32'h0, 5'd0, 32'hCAFEF00D, 0, 0);
        chk("x0_no_rfwe", cnt_rfwe - w0, 0); chk("x0_done", cnt_done - d0, 1);

        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom % 2);
            if ($urandom % 8 == 0) f3 = 3'($urandom);
            else if (st)           f3 = 3'($urandom % 3);
            else case ($urandom % 5)
                0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
            endcase
            b = $urandom; off = 12'($urandom);
            if ($urandom % 3 != 0) begin b[1:0] = 2'b00; off[1:0] = 2'b00; end
            do_op(st, f3, b, off, $urandom, 5'($urandom), $urandom,
                  int'($urandom % 4), ($urandom % 5) == 0);
            idle_cycles(int'($urandom % 3));
        end

        // asynchronous reset while waiting for ack
        chk_en = 0;
        start = 1; is_store = 0; funct3 = 3'd2; base = 32'h40; offset = 0; dest = 5'd7;
        step();
        start = 0;
        chk("rst_mid_req_up", mem_req, 1);
        step();
        #2 rst_n = 0;
        #1;
        chk("rst_mid_req", mem_req, 0); chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);   chk("rst_mid_rfwe", rf_we, 0);
        step(); step();
        rst_n = 1;
        d0 = cnt_done; w0 = cnt_rfwe;
        mem_ack = 1; mem_rdata = 32'h55AA55AA;
        step();
        mem_ack = 0;
        step(); step(); step();
        chk("rst_after_no_done", cnt_done - d0, 0);
        chk("rst_after_no_rfwe", cnt_rfwe - w0, 0);
        chk("rst_after_idle", busy, 0);

        set_idle();
        chk_en = 1;
        do_op(0, 3'd5, 32'h500, 12'd2, 32'h0, 5'd12, 32'h8001_7FFF, 1, 0);
        chk("lhu_after_rst", cap_rd, 32'h00008001);
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
